// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one DPRAM controller command port between two
// requesters, with one pending request per port and a WAIT-state watchdog.
//
// state | meaning
// IDLE  | no command outstanding; grant a pending port if any
// ISSUE | RD or WR is high for this single cycle
// WAIT  | command issued; wait for Done or watchdog expiry
module dpram_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          ar,
  input  logic          p0_rd,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_a,
  input  logic [DW-1:0] p0_din,
  output logic          p0_busy,
  output logic          p0_done,
  output logic          p0_err,
  output logic [DW-1:0] p0_dout,
  input  logic          p1_rd,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_a,
  input  logic [DW-1:0] p1_din,
  output logic          p1_busy,
  output logic          p1_done,
  output logic          p1_err,
  output logic [DW-1:0] p1_dout,
  output logic          RD,
  output logic          WR,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DIn,
  input  logic [DW-1:0] DOut,
  input  logic          Done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          pend0_q, pend0_d, op0_q, op0_d;
  logic          pend1_q, pend1_d, op1_q, op1_d;
  logic          owner_q, owner_d, last_q, last_d, op_q, op_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] din_q, din_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic          gnt, g_wr, fin, abort;
  logic          busy0, busy1;

  // A port stays busy from strobe acceptance until the edge its done pulse starts
  assign busy0 = pend0_q | ((state_q != S_IDLE) & ~owner_q);
  assign busy1 = pend1_q | ((state_q != S_IDLE) & owner_q);

  always_comb begin
    state_d = state_q;
    pend0_d = pend0_q;
    op0_d   = op0_q;
    pend1_d = pend1_q;
    op1_d   = op1_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    din_d   = din_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdog_d  = wdog_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    gnt     = 1'b0;
    g_wr    = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;

    // write wins over a simultaneous read strobe
    if (!busy0 && (p0_rd || p0_wr)) begin
      pend0_d = 1'b1;
      op0_d   = p0_wr;
    end
    if (!busy1 && (p1_rd || p1_wr)) begin
      pend1_d = 1'b1;
      op1_d   = p1_wr;
    end

    case (state_q)
      S_IDLE: begin
        if (pend0_q || pend1_q) begin
          gnt     = (pend0_q && pend1_q) ? ~last_q : pend1_q;
          g_wr    = gnt ? op1_q : op0_q;
          owner_d = gnt;
          last_d  = gnt;
          op_d    = g_wr;
          a_d     = gnt ? p1_a : p0_a;
          if (g_wr) din_d = gnt ? p1_din : p0_din;
          rd_d    = ~g_wr;
          wr_d    = g_wr;
          wdog_d  = 8'd0;
          state_d = S_ISSUE;
          if (gnt) pend1_d = 1'b0;
          else     pend0_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (Done) fin = 1'b1;
        else      state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          fin = 1'b1;
        end else if (wdog_q == TO_LAST) begin
          fin   = 1'b1;
          abort = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_IDLE;
      wdog_d  = 8'd0;
      if (owner_q) begin
        done1_d = 1'b1;
        err1_d  = abort;
        if (!abort && !op_q) dout1_d = DOut;
      end else begin
        done0_d = 1'b1;
        err0_d  = abort;
        if (!abort && !op_q) dout0_d = DOut;
      end
    end
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state_q <= S_IDLE;
      pend0_q <= 1'b0;
      op0_q   <= 1'b0;
      pend1_q <= 1'b0;
      op1_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 1'b0;
      a_q     <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdog_q  <= 8'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      op0_q   <= op0_d;
      pend1_q <= pend1_d;
      op1_q   <= op1_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdog_q  <= wdog_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  assign p0_busy = busy0;
  assign p1_busy = busy1;
  assign p0_done = done0_q;
  assign p1_done = done1_q;
  assign p0_err  = err0_q;
  assign p1_err  = err1_q;
  assign p0_dout = dout0_q;
  assign p1_dout = dout1_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign A       = a_q;
  assign DIn     = din_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a small DPRAM controller stub
// (configurable latency, zero-wait and never-done modes).
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        ar;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [9:0]  p0_a, p1_a;
  logic [15:0] p0_din, p1_din;
  logic        p0_busy, p0_done, p0_err, p1_busy, p1_done, p1_err;
  logic [15:0] p0_dout, p1_dout;
  logic        RD, WR, Done;
  logic [9:0]  A;
  logic [15:0] DIn, DOut;

  int checks = 0;
  int failures = 0;

  dpram_arbiter #(.AW(10), .DW(16), .TIMEOUT(15)) dut (
    .clk(clk), .ar(ar),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_a(p0_a), .p0_din(p0_din),
    .p0_busy(p0_busy), .p0_done(p0_done), .p0_err(p0_err), .p0_dout(p0_dout),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_a(p1_a), .p1_din(p1_din),
    .p1_busy(p1_busy), .p1_done(p1_done), .p1_err(p1_err), .p1_dout(p1_dout),
    .RD(RD), .WR(WR), .A(A), .DIn(DIn), .DOut(DOut), .Done(Done)
  );

  always #5 clk = ~clk;

  // Controller stub
  logic        done_r = 1'b0, spur = 1'b0, zw = 1'b0, never = 1'b0, act = 1'b0;
  int          lat = 2;
  int          cnt = 0;
  logic [15:0] dout_r = 16'h0;
  logic [9:0]  saddr = 10'h0;
  logic [15:0] mem [0:1023];

  assign Done = zw ? (RD | WR) : (done_r | spur);
  assign DOut = zw ? mem[A] : dout_r;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (act && !never) begin
      if (cnt <= 1) begin
        done_r <= 1'b1;
        dout_r <= mem[saddr];
        act    <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (RD || WR) begin
      act   <= !never && !zw;
      cnt   <= lat - 1;
      saddr <= A;
      if (WR) mem[A] <= DIn;
    end
  end

  // Bus monitor
  int         ncmd = 0, nrd = 0, nwr = 0, nboth = 0, ovl = 0;
  int         nd0 = 0, nd1 = 0, ne0 = 0, ne1 = 0, lidx = 0;
  bit         inflight = 1'b0;
  logic [9:0] alog [0:63];

  always @(negedge clk) begin
    if (RD && WR) nboth <= nboth + 1;
    if (RD || WR) begin
      ncmd <= ncmd + 1;
      if (RD) nrd <= nrd + 1;
      if (WR) nwr <= nwr + 1;
      if (inflight) ovl <= ovl + 1;
      alog[lidx % 64] <= A;
      lidx <= lidx + 1;
    end
    if (p0_done) nd0 <= nd0 + 1;
    if (p1_done) nd1 <= nd1 + 1;
    if (p0_err) ne0 <= ne0 + 1;
    if (p1_err) ne1 <= ne1 + 1;
    if (ar) inflight <= 1'b0;
    else if (RD || WR) inflight <= 1'b1;
    else if (p0_done || p1_done) inflight <= 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int port, input logic rd, input logic wr,
                       input logic [9:0] a, input logic [15:0] d);
    if (port == 0) begin p0_rd = rd; p0_wr = wr; p0_a = a; p0_din = d; end
    else           begin p1_rd = rd; p1_wr = wr; p1_a = a; p1_din = d; end
    tick();
    p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  task automatic wait_done(input int port, input int maxc, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      seen = (port != 0) ? p1_done : p0_done;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s_cmd, s_rd, s_wr, s_d0, s_d1, s_e0, s_e1, base;
    bit ok;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    ar = 1'b1;
    p0_rd = 0; p0_wr = 0; p1_rd = 0; p1_wr = 0;
    p0_a = '0; p1_a = '0; p0_din = '0; p1_din = '0;
    tick(); tick();
    ar = 1'b0;

    // reset state
    chk("rst_rdwr", {30'b0, RD, WR}, 32'd0);
    chk("rst_a_din", {6'b0, A, DIn}, 32'd0);
    chk("rst_busy_done", {28'b0, p0_busy, p1_busy, p0_done, p1_done}, 32'd0);
    chk("rst_dout", {p0_dout, p1_dout}, 32'd0);

    // p0 write, stub latency 2
    issue(0, 0, 1, 10'h005, 16'h1234);
    chk("w_busy_after_strobe", p0_busy, 1);
    chk("w_no_cmd_yet", WR, 0);
    tick();
    chk("w_wr_pulse", {30'b0, RD, WR}, 32'd1);
    chk("w_addr", A, 10'h005);
    chk("w_din", DIn, 16'h1234);
    tick();
    chk("w_wr_one_cycle", WR, 0);
    chk("w_done_early_e2", p0_done, 0);
    tick();
    chk("w_done_early_e3", p0_done, 0);
    tick();
    chk("w_done", p0_done, 1);
    chk("w_busy_clear", p0_busy, 0);
    chk("w_err", p0_err, 0);
    tick();
    chk("w_done_one_cycle", p0_done, 0);

    // p0 read back
    issue(0, 1, 0, 10'h005, 16'h0);
    tick();
    chk("r_rd_pulse", {30'b0, RD, WR}, 32'd2);
    tick(); tick(); tick();
    chk("r_done", p0_done, 1);
    chk("r_dout", p0_dout, 16'h1234);
    chk("r_p1_dout_untouched", p1_dout, 16'h0);

    // p1 write, then zero-wait p1 read
    issue(1, 0, 1, 10'h3FF, 16'hBEEF);
    wait_done(1, 20, "p1w_done_timeout");
    chk("p1w_dout_unchanged", p1_dout, 16'h0);
    tick();
    zw = 1'b1;
    issue(1, 1, 0, 10'h3FF, 16'h0);
    tick();
    chk("zw_rd_pulse", RD, 1);
    chk("zw_not_done_yet", p1_done, 0);
    tick();
    zw = 1'b0;
    chk("zw_done", p1_done, 1);
    chk("zw_dout", p1_dout, 16'hBEEF);
    chk("zw_busy_clear", p1_busy, 0);
    tick();

    // spurious Done while idle
    s_cmd = ncmd; s_d0 = nd0; s_d1 = nd1;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("idle_done_ignored", {30'b0, p0_done, p1_done}, 32'd0);
    tick();
    chk("idle_done_no_pulses", nd0 + nd1 - s_d0 - s_d1, 32'd0);
    chk("idle_done_no_cmd", ncmd - s_cmd, 32'd0);

    // simultaneous write strobes, four rounds: grant order 0,1,0,1,...
    base = lidx; s_d0 = nd0; s_d1 = nd1;
    for (int r = 0; r < 4; r++) begin
      p0_wr = 1; p0_a = 10'(10'h010 + r); p0_din = 16'(16'hA000 + r);
      p1_wr = 1; p1_a = 10'(10'h020 + r); p1_din = 16'(16'hB000 + r);
      tick();
      p0_wr = 0; p1_wr = 0;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        tick();
        ok = (nd0 >= s_d0 + r + 1) && (nd1 >= s_d1 + r + 1) && !p0_busy && !p1_busy;
      end
      chk("tie_round_timeout", {31'b0, ok}, 32'd1);
    end
    tick();
    for (int k = 0; k < 8; k++)
      chk("tie_grant_order", alog[(base + k) % 64],
          (k % 2 == 0) ? 10'(10'h010 + k / 2) : 10'(10'h020 + k / 2));
    chk("tie_p0_dones", nd0 - s_d0, 32'd4);
    chk("tie_p1_dones", nd1 - s_d1, 32'd4);
    chk("tie_no_overlap", ovl, 32'd0);
    chk("tie_never_rd_and_wr", nboth, 32'd0);

    // watchdog abort on p1, then pending p0 is served
    never = 1'b1;
    issue(1, 1, 0, 10'h3FF, 16'h0);
    tick(); tick();
    p0_wr = 1; p0_a = 10'h007; p0_din = 16'h5555;
    tick();
    p0_wr = 0;
    chk("to_p0_pending", p0_busy, 1);
    repeat (13) tick();
    chk("to_not_yet", p1_done, 0);
    chk("to_busy_held", p1_busy, 1);
    tick();
    chk("to_done_err", {30'b0, p1_done, p1_err}, 32'd3);
    chk("to_dout_unchanged", p1_dout, 16'hBEEF);
    chk("to_p1_busy_clear", p1_busy, 0);
    never = 1'b0;
    tick();
    chk("to_err_one_cycle", {30'b0, p1_done, p1_err}, 32'd0);
    chk("to_p0_granted_wr", {30'b0, RD, WR}, 32'd1);
    chk("to_p0_addr", A, 10'h007);
    wait_done(0, 20, "to_p0_done_timeout");
    chk("to_p0_no_err", p0_err, 0);
    tick();

    // rd+wr together, strobe while busy, strobe on the done edge
    s_cmd = ncmd; s_rd = nrd; s_wr = nwr;
    p0_rd = 1; p0_wr = 1; p0_a = 10'h008; p0_din = 16'hAAAA;
    tick();
    p0_wr = 0;
    tick();
    p0_rd = 0;
    chk("rw_wr_only", {30'b0, RD, WR}, 32'd1);
    tick(); tick();
    p0_rd = 1;
    tick();
    p0_rd = 0;
    chk("rw_done", p0_done, 1);
    repeat (5) tick();
    chk("rw_single_cmd", ncmd - s_cmd, 32'd1);
    chk("rw_wr_count", nwr - s_wr, 32'd1);
    chk("rw_no_rd", nrd - s_rd, 32'd0);
    chk("rw_idle_after", p0_busy, 0);
    chk("rw_dout_kept", p0_dout, 16'h1234);
    chk("rw_mem_written", mem[8], 16'hAAAA);

    // async reset during WAIT
    never = 1'b1;
    issue(1, 1, 0, 10'h3FF, 16'h0);
    tick(); tick();
    chk("ar_pre_busy", p1_busy, 1);
    chk("ar_pre_addr", A, 10'h3FF);
    #2 ar = 1'b1;
    #1;
    chk("ar_async_busy", {30'b0, p0_busy, p1_busy}, 32'd0);
    chk("ar_async_cmd", {30'b0, RD, WR}, 32'd0);
    chk("ar_async_addr", A, 10'h0);
    chk("ar_async_done_err", {30'b0, p1_done, p1_err}, 32'd0);
    chk("ar_async_dout", {p0_dout, p1_dout}, 32'd0);
    tick();
    #2 ar = 1'b0;
    never = 1'b0;
    s_d0 = nd0; s_d1 = nd1; s_e0 = ne0; s_e1 = ne1;
    p0_wr = 1; p0_a = 10'h030; p0_din = 16'h0001;
    p1_wr = 1; p1_a = 10'h031; p1_din = 16'h0002;
    tick();
    p0_wr = 0; p1_wr = 0;
    tick();
    chk("ar_p0_wins_tie", {21'b0, WR, A}, {21'b0, 1'b1, 10'h030});
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (nd0 == s_d0 + 1) && (nd1 == s_d1 + 1) && !p0_busy && !p1_busy;
    end
    chk("ar_after_both_done", {31'b0, ok}, 32'd1);
    chk("ar_after_no_err", (ne0 - s_e0) + (ne1 - s_e1), 32'd0);
    chk("ar_mem_p1", mem[10'h031], 16'h0002);
    chk("final_no_overlap", ovl, 32'd0);
    chk("final_never_rd_and_wr", nboth, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
